// File: rtl/input_cond_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Shared defaults and width helpers for the input conditioner and its
// per-channel debounce logic.
// -----------------------------------------------------------------------------
package input_cond_pkg;

  localparam int DEF_N            = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_TICK_DIV     = 25000;  // ~1 ms at 25 MHz
  localparam int DEF_DB_SAMPLES   = 8;
  localparam int DEF_REPEAT_DELAY = 400;
  localparam int DEF_REPEAT_RATE  = 50;

  // Width of a counter that must hold values up to n without wrapping.
  // The extra bit keeps n itself representable when n is a power of two.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One conditioned input: synchroniser, polarity normalisation, tick-based
// debounce, press/release pulse registers and optional auto-repeat.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_step     one-cycle sample strobe (shared tick already gated by enable)
//   i_raw      unsynchronised pad input
//   o_level    debounced state, 1 = pressed
//   o_press    1-cycle pulse on accepted press and on each repeat
//   o_release  1-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter logic ACTIVE_HIGH  = 1'b1,
  parameter int   SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int   DB_SAMPLES   = DEF_DB_SAMPLES,
  parameter logic REPEAT_EN    = 1'b0,
  parameter int   REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int   REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_step,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = cnt_width(DB_SAMPLES);
  localparam int RW = cnt_width(REPEAT_DELAY);

  localparam logic [CW-1:0] DB_LAST    = CW'(DB_SAMPLES - 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  // After a repeat, rc restarts this far below the trigger so the next
  // repeat lands REPEAT_RATE ticks later. A rate longer than the delay
  // degenerates to repeating every REPEAT_DELAY ticks.
  localparam logic [RW-1:0] RPT_RELOAD = (REPEAT_DELAY > REPEAT_RATE) ?
                                         RW'(REPEAT_DELAY - REPEAT_RATE) : '0;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [RW-1:0]          r_rc;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;

  logic                   w_pressed;
  logic [CW-1:0]          w_cntNext;
  logic [RW-1:0]          w_rcNext;
  logic                   w_levelNext;
  logic                   w_pressNext;
  logic                   w_releaseNext;

  // The chain resets to the idle pad value so that no phantom press is
  // seen while it refills after reset. It shifts regardless of enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{~ACTIVE_HIGH}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_pressed = ~(r_sync[SYNC_STAGES-1] ^ ACTIVE_HIGH);

  always_comb begin
    w_cntNext     = r_cnt;
    w_rcNext      = r_rc;
    w_levelNext   = r_level;
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;

    if (i_step) begin
      if (w_pressed == r_level) begin
        w_cntNext = '0;
      end else if (r_cnt == DB_LAST) begin
        w_levelNext   = ~r_level;
        w_cntNext     = '0;
        w_pressNext   = ~r_level;
        w_releaseNext = r_level;
      end else begin
        w_cntNext = r_cnt + 1'b1;
      end

      // Any accept clears rc, which also gives an accept priority over a
      // repeat falling on the same tick.
      if (REPEAT_EN) begin
        if (w_levelNext != r_level) begin
          w_rcNext = '0;
        end else if (r_level) begin
          if (r_rc == RPT_LAST) begin
            w_rcNext    = RPT_RELOAD;
            w_pressNext = 1'b1;
          end else begin
            w_rcNext = r_rc + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_rc      <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_cnt     <= w_cntNext;
      r_rc      <= w_rcNext;
      r_level   <= w_levelNext;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Conditions N raw pad inputs for the game cores: per-bit polarity,
// synchroniser, tick-based debounce, edge pulses and optional auto-repeat.
// One prescaler generates the sample tick shared by every channel.
// Parameter minimums: SYNC_STAGES >= 2, TICK_DIV/DB_SAMPLES/REPEAT_* >= 1.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_ena       1 = run, 0 = freeze counters and state, no pulses
//   i_raw_in    unsynchronised pad inputs [N]
//   o_level     debounced state, 1 = pressed [N]
//   o_level_n   inverse of o_level, for active-low core key ports [N]
//   o_press     1-cycle pulse on accepted press and each repeat [N]
//   o_release   1-cycle pulse on accepted release [N]
//   o_tick      1-cycle sample strobe
// -----------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int           N            = DEF_N,
  parameter logic [N-1:0] ACTIVE_HIGH  = {N{1'b1}},
  parameter int           SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int           TICK_DIV     = DEF_TICK_DIV,
  parameter int           DB_SAMPLES   = DEF_DB_SAMPLES,
  parameter logic [N-1:0] REPEAT_EN    = {N{1'b0}},
  parameter int           REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int           REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ena,
  input  logic [N-1:0] i_raw_in,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_level_n,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic         o_tick
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic          w_step;

  // Tick is registered from the terminal count, so the first strobe appears
  // TICK_DIV cycles after reset release. Disabling holds the count and
  // drops the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (i_ena) begin
      if (r_pre == PRE_LAST) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_pre  <= r_pre + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // A tick still high in the cycle enable drops must not advance channels.
  assign w_step = r_tick & i_ena;

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_HIGH (ACTIVE_HIGH[g]),
      .SYNC_STAGES (SYNC_STAGES),
      .DB_SAMPLES  (DB_SAMPLES),
      .REPEAT_EN   (REPEAT_EN[g]),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_step   (w_step),
      .i_raw    (i_raw_in[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g])
    );
  end

  assign o_level_n = ~o_level;
  assign o_tick    = r_tick;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Directed bench for input_conditioner with N=4, TICK_DIV=4, DB_SAMPLES=3,
// SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_HIGH=4'b0111 and
// auto-repeat on channel 2. Expected pulses are queued, tagged with the
// index of the tick on which they must be accepted, and matched against
// every pulse the DUT emits.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] raw = 4'b1000;
  logic [3:0] o_level;
  logic [3:0] o_level_n;
  logic [3:0] o_press;
  logic [3:0] o_release;
  logic       o_tick;

  typedef struct {
    int         tickAt;
    logic [3:0] pr;
    logic [3:0] rl;
  } pulse_t;

  pulse_t sb[$];
  int     total = 0;
  int     bad = 0;
  int     tickIdx = 0;

  input_conditioner #(
    .N           (4),
    .ACTIVE_HIGH (4'b0111),
    .SYNC_STAGES (2),
    .TICK_DIV    (4),
    .DB_SAMPLES  (3),
    .REPEAT_EN   (4'b0100),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_ena    (ena),
    .i_raw_in (raw),
    .o_level  (o_level),
    .o_level_n(o_level_n),
    .o_press  (o_press),
    .o_release(o_release),
    .o_tick   (o_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    #1 raw = v;
  endtask

  task automatic expectPulse(input int at, input logic [3:0] pr,
                             input logic [3:0] rl);
    pulse_t e;
    e.tickAt = at;
    e.pr     = pr;
    e.rl     = rl;
    sb.push_back(e);
  endtask

  // Returns on the posedge that consumes the n-th tick from now.
  task automatic waitTicks(input int n);
    int target;
    int guard;
    target = tickIdx + n;
    guard  = 0;
    while (tickIdx < target && guard < 40 * n + 40) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("tick_wait", 32'(tickIdx >= target), 32'd1);
  endtask

  // Pulse monitor: every emitted pulse must match the head of the queue,
  // including the tick it was accepted on.
  always @(negedge clk) begin
    if (rst_n && ((o_press | o_release) != 4'b0000)) begin
      pulse_t e;
      checkOutput("pulse_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pulse_tick", 32'(tickIdx), 32'(e.tickAt));
        checkOutput("pulse_press", 32'(o_press), 32'(e.pr));
        checkOutput("pulse_release", 32'(o_release), 32'(e.rl));
      end
    end
    if (o_tick === 1'b1) tickIdx++;
  end

  initial begin
    int k;
    int a;
    int offs[6];
    offs = '{10, 13, 16, 19, 22, 25};

    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      raw = 4'(i * 5);
      checkOutput("rst_level", 32'(o_level), 32'h0);
      checkOutput("rst_level_n", 32'(o_level_n), 32'hF);
    end
    checkOutput("rst_press", 32'(o_press), 32'h0);
    checkOutput("rst_release", 32'(o_release), 32'h0);
    checkOutput("rst_tick", 32'(o_tick), 32'h0);
    raw = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;

    // Tick cadence: high on cycles 4 and 8 after release
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("tick_cadence", 32'(o_tick), 32'((c % 4) == 0));
    end

    // Clean press and release on channel 0
    waitTicks(1);
    k = tickIdx;
    applyStimulus(4'b1001);
    expectPulse(k + 3, 4'b0001, 4'b0000);
    waitTicks(5);
    checkOutput("press_level", 32'(o_level), 32'h1);
    checkOutput("press_level_n", 32'(o_level_n), 32'hE);
    k = tickIdx;
    applyStimulus(4'b1000);
    expectPulse(k + 3, 4'b0000, 4'b0001);
    waitTicks(5);
    checkOutput("release_level", 32'(o_level), 32'h0);

    // Bounce on channel 1: flips every 2 ticks, never accepted
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b1010 : 4'b1000);
      waitTicks(2);
    end
    checkOutput("bounce_level", 32'(o_level), 32'h0);

    // Active-low channel 3
    k = tickIdx;
    applyStimulus(4'b0000);
    expectPulse(k + 3, 4'b1000, 4'b0000);
    waitTicks(5);
    checkOutput("pol_level", 32'(o_level), 32'h8);
    checkOutput("pol_level_n", 32'(o_level_n), 32'h7);
    k = tickIdx;
    applyStimulus(4'b1000);
    expectPulse(k + 3, 4'b0000, 4'b1000);
    waitTicks(5);
    checkOutput("pol_released", 32'(o_level), 32'h0);

    // Auto-repeat on channel 2
    k = tickIdx;
    applyStimulus(4'b1100);
    a = k + 3;
    expectPulse(a, 4'b0100, 4'b0000);
    for (int i = 0; i < 6; i++) expectPulse(a + offs[i], 4'b0100, 4'b0000);
    waitTicks(5);
    checkOutput("rpt_level", 32'(o_level), 32'h4);
    waitTicks(a + 25 - tickIdx);
    applyStimulus(4'b1000);
    expectPulse(tickIdx + 3, 4'b0000, 4'b0100);
    waitTicks(15);
    checkOutput("rpt_released", 32'(o_level), 32'h0);

    // Freeze after 2 of 3 debounce ticks
    k = tickIdx;
    applyStimulus(4'b1001);
    expectPulse(k + 3, 4'b0001, 4'b0000);
    waitTicks(2);
    #1 ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("freeze_tick", 32'(o_tick), 32'h0);
      checkOutput("freeze_level", 32'(o_level), 32'h0);
    end
    @(posedge clk);
    #1 ena = 1'b1;
    waitTicks(2);
    checkOutput("resume_level", 32'(o_level), 32'h1);

    // Reset pulsed mid-debounce of a release
    applyStimulus(4'b1000);
    waitTicks(2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_level", 32'(o_level), 32'h0);
    checkOutput("async_rst_level_n", 32'(o_level_n), 32'hF);
    checkOutput("async_rst_press", 32'(o_press), 32'h0);
    checkOutput("async_rst_release", 32'(o_release), 32'h0);
    checkOutput("async_rst_tick", 32'(o_tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    waitTicks(6);
    checkOutput("post_rst_level", 32'(o_level), 32'h0);

    // Channel works normally after reset
    k = tickIdx;
    applyStimulus(4'b1001);
    expectPulse(k + 3, 4'b0001, 4'b0000);
    waitTicks(5);
    checkOutput("post_rst_press", 32'(o_level), 32'h1);

    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
